// File: rtl/crossbar_pkg.sv
// Shared definitions for the round-robin packet crossbar: default port sizing
// and small modulo index helpers that avoid any clog2 dependency.
package crossbar_pkg;

    localparam int W = 2;
    localparam int N = 1 << W;

    typedef logic [W-1:0] port_idx_t;

    function automatic int wrap_idx(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

    function automatic int next_idx(input int k, input int n);
        return wrap_idx(k, 1, n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one crossbar output. The search starts at the
// internal pointer, which moves past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant,
    output logic [W-1:0] gidx
);
    import crossbar_pkg::*;

    logic [W-1:0] ptr_reg;
    logic [W-1:0] cand;
    logic [W-1:0] sel;
    logic         found;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = W'(wrap_idx(int'(ptr_reg), i, N));
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        grant = '0;
        if (en && found) begin
            grant[sel] = 1'b1;
        end
        gidx = sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (en && found) begin
            ptr_reg <= W'(next_idx(int'(sel), N));
        end
    end

endmodule

// File: rtl/crossbar_rr.sv
// N-port valid/ready crossbar: each output has its own round-robin arbiter
// and a single registered stage that can pop and refill on the same edge.
module crossbar_rr #(
    parameter int  DW = 16,
    parameter int  W  = 2,
    localparam int N  = 1 << W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_valid,
    input  logic [N-1:0][DW-1:0] i_data,
    input  logic [N-1:0][W-1:0]  i_dest,
    output logic [N-1:0]         i_ready,
    output logic [N-1:0]         o_valid,
    output logic [N-1:0][DW-1:0] o_data,
    output logic [N-1:0][W-1:0]  o_src,
    input  logic [N-1:0]         o_ready
);
    import crossbar_pkg::*;

    logic [N-1:0]  req [N];
    logic [N-1:0]  grant [N];
    logic [W-1:0]  gidx [N];
    logic [N-1:0]  en;
    logic [N-1:0]  ready_next;

    logic          valid_reg [N];
    logic [DW-1:0] data_reg [N];
    logic [W-1:0]  src_reg [N];

    genvar gi, gk;
    generate
        for (gi = 0; gi < N; gi++) begin : g_out
            for (gk = 0; gk < N; gk++) begin : g_req
                assign req[gi][gk] = i_valid[gk] && (i_dest[gk] == W'(gi));
            end

            // A full, stalled output issues no grant; reset blocks all accepts.
            assign en[gi] = (!valid_reg[gi] || o_ready[gi]) && !rst;

            rr_arbiter #(
                .N (N),
                .W (W)
            ) u_arb (
                .clk   (clk),
                .rst   (rst),
                .req   (req[gi]),
                .en    (en[gi]),
                .grant (grant[gi]),
                .gidx  (gidx[gi])
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                    src_reg[gi]   <= '0;
                end else if (|grant[gi]) begin
                    valid_reg[gi] <= 1'b1;
                    data_reg[gi]  <= i_data[gidx[gi]];
                    src_reg[gi]   <= gidx[gi];
                end else if (o_ready[gi]) begin
                    valid_reg[gi] <= 1'b0;
                end
            end

            assign o_valid[gi] = valid_reg[gi];
            assign o_data[gi]  = data_reg[gi];
            assign o_src[gi]   = src_reg[gi];
        end
    endgenerate

    // Each input targets one output, so OR-ing the grant rows never collides.
    always_comb begin
        ready_next = '0;
        for (int j = 0; j < N; j++) begin
            ready_next = ready_next | grant[j];
        end
    end

    assign i_ready = ready_next;

endmodule

// File: tb/tb_crossbar_rr.sv
// Self-checking bench for crossbar_rr: directed scenarios plus constrained
// random traffic, all compared against a per-output round-robin model.
module tb_crossbar_rr;

    localparam int DW = 16;
    localparam int W  = 2;
    localparam int N  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         i_valid;
    logic [N-1:0][DW-1:0] i_data;
    logic [N-1:0][W-1:0]  i_dest;
    logic [N-1:0]         i_ready;
    logic [N-1:0]         o_valid;
    logic [N-1:0][DW-1:0] o_data;
    logic [N-1:0][W-1:0]  o_src;
    logic [N-1:0]         o_ready;

    always #5 clk = ~clk;

    crossbar_rr #(.DW(DW), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_dest  (i_dest),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_src   (o_src),
        .o_ready (o_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference state: one holding slot and one priority pointer per output.
    logic          m_valid [N];
    logic [DW-1:0] m_data [N];
    int            m_src [N];
    int            m_ptr [N];
    int            exp_g [N];
    logic [N-1:0]  acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic [N-1:0]         r;
        logic [N-1:0]         ev;
        logic [N-1:0][DW-1:0] ed;
        logic [N-1:0][W-1:0]  es;
        int k;
        #1;
        r = '0;
        for (int j = 0; j < N; j++) begin
            exp_g[j] = -1;
            if (!rst && (!m_valid[j] || o_ready[j])) begin
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr[j] + i) % N;
                    if (exp_g[j] < 0 && i_valid[k] && int'(i_dest[k]) == j)
                        exp_g[j] = k;
                end
            end
            if (exp_g[j] >= 0)
                r = r | (N'(1) << exp_g[j]);
        end
        check("i_ready", 64'(i_ready), 64'(r));
        acc = r;
        @(posedge clk);
        for (int j = 0; j < N; j++) begin
            if (rst) begin
                m_valid[j] = 1'b0;
                m_data[j]  = '0;
                m_src[j]   = 0;
                m_ptr[j]   = 0;
            end else if (exp_g[j] >= 0) begin
                m_valid[j] = 1'b1;
                m_data[j]  = i_data[exp_g[j]];
                m_src[j]   = exp_g[j];
                m_ptr[j]   = (exp_g[j] + 1) % N;
            end else if (m_valid[j] && o_ready[j]) begin
                m_valid[j] = 1'b0;
            end
        end
        #1;
        for (int j = 0; j < N; j++) begin
            ev[j] = m_valid[j];
            ed[j] = m_data[j];
            es[j] = W'(m_src[j]);
        end
        check("o_valid", 64'(o_valid), 64'(ev));
        check("o_data", 64'(o_data), 64'(ed));
        check("o_src", 64'(o_src), 64'(es));
        $display("cyc %0d rst=%0b i_valid=%b accepted=%b o_valid=%b o_src=%h o_data=%h",
                 cyc, rst, i_valid, acc, o_valid, o_src, o_data);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_valid = '0;
        i_data  = '0;
        i_dest  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [N-1:0][DW-1:0] saved;
    int fair_exp [5] = '{1, 3, 1, 1, 3};

    initial begin
        for (int j = 0; j < N; j++) begin
            m_valid[j] = 1'b0;
            m_data[j]  = '0;
            m_src[j]   = 0;
            m_ptr[j]   = 0;
        end
        acc = '0;
        rst = 1'b1;
        idle_inputs();
        o_ready = '1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("reset_o_valid", 64'(o_valid), 64'(0));

        // Permutation: every input to the next output, all in one cycle.
        for (int k = 0; k < N; k++) begin
            i_dest[k] = W'((k + 1) % N);
            i_data[k] = DW'($urandom);
        end
        saved   = i_data;
        i_valid = '1;
        step();
        check("perm_ready", 64'(acc), 64'(4'hF));
        for (int k = 0; k < N; k++) begin
            check("perm_data", 64'(o_data[(k + 1) % N]), 64'(saved[k]));
            check("perm_src", 64'(o_src[(k + 1) % N]), 64'(k));
        end
        idle_inputs();
        step();

        // Full contention on output 2 from reset.
        do_reset();
        for (int k = 0; k < N; k++) begin
            i_dest[k] = W'(2);
            i_data[k] = DW'($urandom);
        end
        i_valid = '1;
        for (int c = 0; c < 8; c++) begin
            step();
            check("cont_src", 64'(o_src[2]), 64'(c % N));
            for (int k = 0; k < N; k++)
                if (acc[k]) i_data[k] = DW'($urandom);
        end
        idle_inputs();
        step();

        // Backpressure on output 1.
        do_reset();
        i_valid[3] = 1'b1;
        i_dest[3]  = W'(1);
        i_data[3]  = 16'hA5A5;
        step();
        i_valid[3] = 1'b0;
        o_ready[1] = 1'b0;
        i_valid[0] = 1'b1;
        i_dest[0]  = W'(1);
        i_data[0]  = 16'h1234;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_data", 64'(o_data[1]), 64'(16'hA5A5));
            check("bp_src", 64'(o_src[1]), 64'(3));
            check("bp_ready0", 64'(i_ready[0]), 64'(0));
        end
        o_ready[1] = 1'b1;
        step();
        check("bp_accept", 64'(acc[0]), 64'(1));
        check("bp_new_data", 64'(o_data[1]), 64'(16'h1234));
        idle_inputs();
        step();

        // Pop and refill output 0 on the same edge.
        i_valid[2] = 1'b1;
        i_dest[2]  = W'(0);
        for (int c = 0; c < 3; c++) begin
            i_data[2] = DW'($urandom);
            step();
            check("pr_valid", 64'(o_valid[0]), 64'(1));
            check("pr_src", 64'(o_src[0]), 64'(2));
        end
        idle_inputs();
        step();

        // Fairness with a gap: inputs 1 and 3 on output 0.
        do_reset();
        i_valid[1] = 1'b1;
        i_valid[3] = 1'b1;
        i_dest[1]  = W'(0);
        i_dest[3]  = W'(0);
        for (int c = 0; c < 5; c++) begin
            i_valid[3] = (c != 3);
            i_data[1]  = DW'($urandom);
            i_data[3]  = DW'($urandom);
            step();
            check("fair_src", 64'(o_src[0]), 64'(fair_exp[c]));
        end
        idle_inputs();
        step();

        // Reset while every output is full and stalled.
        for (int k = 0; k < N; k++) begin
            i_dest[k] = W'((k + 1) % N);
            i_data[k] = DW'($urandom);
        end
        i_valid = '1;
        o_ready = '0;
        step();
        check("mid_full", 64'(o_valid), 64'(4'hF));
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(i_ready), 64'(0));
        step();
        check("mid_rst_valid", 64'(o_valid), 64'(0));
        rst = 1'b0;
        o_ready = '1;
        for (int k = 0; k < N; k++) i_dest[k] = W'(2);
        step();
        check("mid_restart_src", 64'(o_src[2]), 64'(0));
        idle_inputs();
        step();

        // Random traffic that honours the hold-until-accepted rule.
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            o_ready = N'($urandom);
            for (int k = 0; k < N; k++) begin
                if (!i_valid[k] || acc[k]) begin
                    i_valid[k] = ($urandom_range(0, 3) != 0);
                    i_dest[k]  = W'($urandom_range(0, N - 1));
                    i_data[k]  = DW'($urandom);
                end
            end
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
